// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with valid/ready handshakes on both sides.
// Single-cycle ops (AND/OR/ADD/SUB/SLT) finish one cycle after accept.
// MUL (shift-add) and DIVU/REMU (restoring) iterate one bit per cycle.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   in_valid   operands/opcode presented      in_ready   op can be accepted
//   data1/2    operands A/B                   ALUOp      operation select
//   out_valid  result and flags valid         out_ready  consumer takes result
//   ALUResult  registered result
//   Zero       ALUResult == 0
//   Overflow   signed overflow (ADD/SUB only)
//   DivZero    DIVU/REMU with data2 == 0
//
// state | meaning
// IDLE  | waiting for an op; in_ready=1
// MUL   | shift-add multiply, one multiplier bit per cycle, LSB first
// DIV   | restoring divide, one quotient bit per cycle, MSB first
// DONE  | result presented; held until out_ready
module seq_alu #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic [2:0]       ALUOp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero,
  output logic             Overflow,
  output logic             DivZero
);

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_MUL  = 3'b011;
  localparam logic [2:0] OP_DIVU = 3'b100;
  localparam logic [2:0] OP_REMU = 3'b101;
  localparam logic [2:0] OP_SUB  = 3'b110;
  localparam logic [2:0] OP_SLT  = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t             state_q;
  logic [2:0]         op_q;
  logic [WIDTH-1:0]   a_q;        // MUL: shifted multiplicand; DIV: dividend / quotient
  logic [WIDTH-1:0]   b_q;        // MUL: shifted multiplier;   DIV: divisor
  logic [WIDTH-1:0]   acc_q;      // MUL: product accumulator;  DIV: partial remainder
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   res_q;
  logic               zero_q;
  logic               ovf_q;
  logic               dz_q;
  logic               out_valid_q;
  logic               in_ready_q;

  logic [WIDTH-1:0]   sum_d;
  logic [WIDTH-1:0]   diff_d;
  logic               slt_d;
  logic               alu_ovf_d;
  logic [WIDTH-1:0]   mul_acc_d;
  logic [WIDTH:0]     rem_sh_d;
  logic [WIDTH:0]     trial_d;
  logic [WIDTH-1:0]   rem_d;
  logic [WIDTH-1:0]   quo_d;
  logic               div_by_zero_d;
  logic [WIDTH-1:0]   fin_res_d;
  logic               fin_zero_d;

  // Single-cycle datapath, driven straight from the inputs in IDLE.
  always_comb begin
    sum_d     = data1 + data2;
    diff_d    = data1 - data2;
    slt_d     = $signed(data1) < $signed(data2);
    alu_ovf_d = 1'b0;
    if (ALUOp == OP_ADD)
      alu_ovf_d = (data1[WIDTH-1] == data2[WIDTH-1]) && (sum_d[WIDTH-1] != data1[WIDTH-1]);
    else if (ALUOp == OP_SUB)
      alu_ovf_d = (data1[WIDTH-1] != data2[WIDTH-1]) && (diff_d[WIDTH-1] != data1[WIDTH-1]);
  end

  // One iteration step of multiply and divide.
  always_comb begin
    mul_acc_d     = acc_q + (b_q[0] ? a_q : '0);
    div_by_zero_d = (b_q == '0);
    rem_sh_d      = {acc_q, a_q[WIDTH-1]};
    trial_d       = rem_sh_d - {1'b0, b_q};
    // Trial subtraction borrows out of the extra top bit when rem_sh < divisor.
    if (!trial_d[WIDTH]) begin
      rem_d = trial_d[WIDTH-1:0];
      quo_d = {a_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_d = rem_sh_d[WIDTH-1:0];
      quo_d = {a_q[WIDTH-2:0], 1'b0};
    end
  end

  // Value that will be registered as ALUResult when DONE is entered.
  always_comb begin
    fin_res_d = res_q;
    case (state_q)
      S_IDLE: begin
        case (ALUOp)
          OP_AND:  fin_res_d = data1 & data2;
          OP_OR:   fin_res_d = data1 | data2;
          OP_ADD:  fin_res_d = sum_d;
          OP_SUB:  fin_res_d = diff_d;
          OP_SLT:  fin_res_d = {{(WIDTH-1){1'b0}}, slt_d};
          default: fin_res_d = '0;
        endcase
      end
      S_MUL: fin_res_d = mul_acc_d;
      S_DIV: begin
        if (div_by_zero_d)
          fin_res_d = (op_q == OP_REMU) ? a_q : '1;
        else
          fin_res_d = (op_q == OP_REMU) ? rem_d : quo_d;
      end
      default: fin_res_d = res_q;
    endcase
    fin_zero_d = (fin_res_d == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      res_q       <= '0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      dz_q        <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            op_q       <= ALUOp;
            a_q        <= data1;
            b_q        <= data2;
            acc_q      <= '0;
            cnt_q      <= CNT_W'(WIDTH);
            in_ready_q <= 1'b0;
            case (ALUOp)
              OP_MUL:           state_q <= S_MUL;
              OP_DIVU, OP_REMU: state_q <= S_DIV;
              default: begin
                res_q       <= fin_res_d;
                zero_q      <= fin_zero_d;
                ovf_q       <= alu_ovf_d;
                dz_q        <= 1'b0;
                out_valid_q <= 1'b1;
                state_q     <= S_DONE;
              end
            endcase
          end
        end
        S_MUL: begin
          acc_q <= mul_acc_d;
          a_q   <= a_q << 1;
          b_q   <= b_q >> 1;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            res_q       <= fin_res_d;
            zero_q      <= fin_zero_d;
            ovf_q       <= 1'b0;
            dz_q        <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_DIV: begin
          if (div_by_zero_d) begin
            res_q       <= fin_res_d;
            zero_q      <= fin_zero_d;
            ovf_q       <= 1'b0;
            dz_q        <= 1'b1;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            acc_q <= rem_d;
            a_q   <= quo_d;
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
              res_q       <= fin_res_d;
              zero_q      <= fin_zero_d;
              ovf_q       <= 1'b0;
              dz_q        <= 1'b0;
              out_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign ALUResult = res_q;
  assign Zero      = zero_q;
  assign Overflow  = ovf_q;
  assign DivZero   = dz_q;

endmodule
